// File: rtl/spi_write_controller.sv
// Queued 16-bit SPI (mode 0) frame writer: commands go into a small FIFO and are
// shifted out MSB first, one frame per nCS assertion, with a fixed gap between frames.
module spi_write_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [6:0]                    cmd_addr,
  input  logic [7:0]                    cmd_data,
  output logic                          SCLK,
  output logic                          COPI,
  output logic                          nCS,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, SETUP, SCLK_HI, SCLK_LO, GAP} state_t;

  state_t      state, state_n;
  logic [7:0]  timer, timer_n;
  logic [3:0]  bitcnt, bitcnt_n;
  logic [3:0]  bit_dn;
  logic        last, last_n;
  logic [15:0] frame, frame_n;
  logic        sclk_n, copi_n, ncs_n, done_n;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push, pop;
  logic [15:0]   head;

  // Fullness uses the registered level only, so a same-cycle pop never opens a slot.
  assign cmd_ready = !rst && (level < LW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (level != '0);
  assign head      = mem[rptr];
  assign busy      = (level != '0) || (state != IDLE);
  assign bit_dn    = bitcnt - 4'd1;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cmd_write, cmd_addr, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= '0;
      bitcnt <= '0;
      last   <= 1'b0;
      frame  <= '0;
      SCLK   <= 1'b0;
      COPI   <= 1'b0;
      nCS    <= 1'b1;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      bitcnt <= bitcnt_n;
      last   <= last_n;
      frame  <= frame_n;
      SCLK   <= sclk_n;
      COPI   <= copi_n;
      nCS    <= ncs_n;
      done   <= done_n;
    end
  end

  // bitcnt names the bit currently on COPI; 'last' marks that bit 0 has been clocked.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    bitcnt_n = bitcnt;
    last_n   = last;
    frame_n  = frame;
    sclk_n   = SCLK;
    copi_n   = COPI;
    ncs_n    = nCS;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          state_n  = SETUP;
          frame_n  = head;
          timer_n  = 8'(CLK_DIV - 1);
          bitcnt_n = 4'd15;
          last_n   = 1'b0;
          ncs_n    = 1'b0;
          sclk_n   = 1'b0;
          copi_n   = head[15];
        end
      end
      SETUP: begin
        if (timer == '0) begin
          state_n = SCLK_HI;
          timer_n = 8'(CLK_DIV - 1);
          sclk_n  = 1'b1;
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      SCLK_HI: begin
        if (timer == '0) begin
          state_n = SCLK_LO;
          timer_n = 8'(CLK_DIV - 1);
          sclk_n  = 1'b0;
          if (bitcnt != 4'd0) begin
            bitcnt_n = bit_dn;
            copi_n   = frame[bit_dn];
          end else begin
            last_n = 1'b1;
          end
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      SCLK_LO: begin
        if (timer == '0) begin
          if (last) begin
            state_n = GAP;
            timer_n = 8'(GAP_CYCLES - 1);
            ncs_n   = 1'b1;
            copi_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = SCLK_HI;
            timer_n = 8'(CLK_DIV - 1);
            sclk_n  = 1'b1;
          end
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      GAP: begin
        if (timer == '0) state_n = IDLE;
        else             timer_n = timer - 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_write_controller.sv
// Directed bench: default instance for queue/frame/reset behaviour, a second
// instance with CLK_DIV=5, GAP_CYCLES=1 for timing scaling.
module tb_spi_write_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       valid, write, ready, busy0, done0;
  logic [6:0] addr;
  logic [7:0] data;
  logic [2:0] level0;
  logic       valid5, write5, ready5, busy5, done5;
  logic [6:0] addr5;
  logic [7:0] data5;
  logic [2:0] level5;
  logic       sclk_v [2];
  logic       copi_v [2];
  logic       ncs_v  [2];
  logic       done_v [2];

  assign done_v[0] = done0;
  assign done_v[1] = done5;

  spi_write_controller u_dut (
    .clk(clk), .rst(rst), .cmd_valid(valid), .cmd_ready(ready), .cmd_write(write),
    .cmd_addr(addr), .cmd_data(data), .SCLK(sclk_v[0]), .COPI(copi_v[0]), .nCS(ncs_v[0]),
    .busy(busy0), .done(done0), .level(level0));

  spi_write_controller #(.CLK_DIV(5), .GAP_CYCLES(1), .FIFO_DEPTH(4)) u_dut5 (
    .clk(clk), .rst(rst), .cmd_valid(valid5), .cmd_ready(ready5), .cmd_write(write5),
    .cmd_addr(addr5), .cmd_data(data5), .SCLK(sclk_v[1]), .COPI(copi_v[1]), .nCS(ncs_v[1]),
    .busy(busy5), .done(done5), .level(level5));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Frame monitor: sampled on falling clk edges, latches per-frame results at nCS rise.
  logic        ps [2];
  logic        pn [2];
  int          low [2], nr [2], run [2], hcnt [2];
  int          hmin [2], hmax [2], lmin [2], lmax [2];
  int          l_low [2], l_nr [2], l_hmin [2], l_hmax [2], l_lmin [2], l_lmax [2];
  int          gap_last [2], done_cnt [2];
  logic [15:0] sh [2];
  logic [15:0] l_frame [2];
  logic [15:0] flog [$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (!ncs_v[i] && pn[i]) begin
        gap_last[i] <= hcnt[i];
        low[i]  <= 1;
        sh[i]   <= '0;
        nr[i]   <= 0;
        run[i]  <= 1;
        hmin[i] <= 1000; hmax[i] <= 0;
        lmin[i] <= 1000; lmax[i] <= 0;
      end else if (!ncs_v[i]) begin
        low[i] <= low[i] + 1;
        if (sclk_v[i] != ps[i]) begin
          if (ps[i]) begin
            hmin[i] <= imin(hmin[i], run[i]);
            hmax[i] <= imax(hmax[i], run[i]);
          end else begin
            lmin[i] <= imin(lmin[i], run[i]);
            lmax[i] <= imax(lmax[i], run[i]);
          end
          run[i] <= 1;
          if (sclk_v[i]) begin
            sh[i] <= {sh[i][14:0], copi_v[i]};
            nr[i] <= nr[i] + 1;
          end
        end else begin
          run[i] <= run[i] + 1;
        end
      end else if (!pn[i]) begin
        l_frame[i] <= sh[i];
        l_low[i]   <= low[i];
        l_nr[i]    <= nr[i];
        l_hmin[i]  <= hmin[i];
        l_hmax[i]  <= hmax[i];
        l_lmin[i]  <= imin(lmin[i], run[i]);
        l_lmax[i]  <= imax(lmax[i], run[i]);
        hcnt[i]    <= 1;
        if (i == 0) flog.push_back(sh[i]);
      end else begin
        hcnt[i] <= hcnt[i] + 1;
      end
      ps[i] <= sclk_v[i];
      pn[i] <= ncs_v[i];
    end
  end

  task automatic push0(input logic [15:0] f);
    int t = 0;
    valid = 1'b1;
    {write, addr, data} = f;
    while (!ready && t < 500) begin @(negedge clk); t++; end
    chk("push_rdy", ready, 1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle0(input int bound);
    int t = 0;
    while (busy0 && t < bound) begin @(negedge clk); t++; end
    chk("idle_to", busy0, 0);
  endtask

  task automatic chk_frame0(input string tag, input logic [15:0] f);
    chk({tag, "_bits"}, l_frame[0], f);
    chk({tag, "_ncs_low"}, l_low[0], 132);
    chk({tag, "_rises"}, l_nr[0], 16);
  endtask

  logic [15:0] fq [6] = '{16'h8101, 16'h8202, 16'h8303, 16'h8404, 16'h8505, 16'h8606};
  int d0, idx, t, cnt;
  logic acc, psl;

  initial begin
    rst = 1'b1;
    valid = 1'b0; write = 1'b0; addr = '0; data = '0;
    valid5 = 1'b0; write5 = 1'b0; addr5 = '0; data5 = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk_v[0], 0);
    chk("rst_copi", copi_v[0], 0);
    chk("rst_ncs", ncs_v[0], 1);
    chk("rst_done", done0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_level", level0, 0);
    chk("rst_ready", ready, 0);
    chk("rst_ready5", ready5, 0);
    chk("rst_level5", level5, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", ready, 1);

    // single write with latency check
    d0 = done_cnt[0];
    @(negedge clk);
    valid = 1'b1; {write, addr, data} = {1'b1, 7'h04, 8'hA5};
    @(negedge clk);
    valid = 1'b0;
    chk("lat_level", level0, 1);
    chk("lat_ncs_hi", ncs_v[0], 1);
    @(negedge clk);
    chk("lat_ncs_lo", ncs_v[0], 0);
    chk("lat_popped", level0, 0);
    chk("lat_busy", busy0, 1);
    wait_idle0(400);
    #1;
    chk_frame0("wr", 16'h84A5);
    chk("wr_hi_min", l_hmin[0], 4);
    chk("wr_hi_max", l_hmax[0], 4);
    chk("wr_lo_min", l_lmin[0], 4);
    chk("wr_lo_max", l_lmax[0], 4);
    chk("wr_done", done_cnt[0] - d0, 1);

    // read frame
    d0 = done_cnt[0];
    push0({1'b0, 7'h02, 8'h00});
    wait_idle0(400);
    #1;
    chk_frame0("rd", 16'h0200);
    chk("rd_done", done_cnt[0] - d0, 1);

    // back-to-back
    d0 = done_cnt[0];
    push0(16'h8011);
    push0(16'h8122);
    wait_idle0(800);
    #1;
    chk("b2b_first", flog[flog.size()-2], 16'h8011);
    chk("b2b_second", flog[flog.size()-1], 16'h8122);
    chk("b2b_gap", gap_last[0], 5);
    chk("b2b_done", done_cnt[0] - d0, 2);

    // full queue with valid held high
    d0 = done_cnt[0];
    idx = 0; t = 0;
    valid = 1'b1;
    while (idx < 6 && t < 2000) begin
      {write, addr, data} = fq[idx];
      acc = ready;
      @(negedge clk);
      t++;
      if (acc) begin
        idx++;
        if (idx == 5) begin
          chk("full_level", level0, 4);
          chk("full_ready", ready, 0);
          chk("full_active", ncs_v[0], 0);
        end
      end
    end
    valid = 1'b0;
    chk("full_all_pushed", idx, 6);
    wait_idle0(1500);
    #1;
    for (int k = 0; k < 6; k++)
      chk($sformatf("full_order%0d", k), flog[flog.size()-6+k], fq[k]);
    chk("full_done", done_cnt[0] - d0, 6);

    // reset mid-frame with two queued
    push0(16'h8033);
    push0(16'h8044);
    push0(16'h8055);
    #1 d0 = done_cnt[0];
    cnt = 0; t = 0; psl = sclk_v[0];
    while (cnt < 8 && t < 500) begin
      @(negedge clk);
      t++;
      if (sclk_v[0] && !psl) cnt++;
      psl = sclk_v[0];
    end
    chk("abort_rise8", cnt, 8);
    chk("abort_queued", level0, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ncs", ncs_v[0], 1);
    chk("abort_done", done0, 0);
    chk("abort_level", level0, 0);
    chk("abort_sclk", sclk_v[0], 0);
    chk("abort_busy", busy0, 0);
    chk("abort_ready", ready, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_stay_idle", ncs_v[0], 1);
    chk("abort_no_busy", busy0, 0);
    #1 chk("abort_no_done", done_cnt[0] - d0, 0);
    push0(16'h8166);
    wait_idle0(400);
    #1;
    chk_frame0("post_rst", 16'h8166);

    // CLK_DIV=5, GAP_CYCLES=1 instance
    d0 = done_cnt[1];
    @(negedge clk);
    valid5 = 1'b1; {write5, addr5, data5} = 16'h8A3C;
    @(negedge clk);
    valid5 = 1'b0;
    t = 0;
    while (!done5 && t < 500) begin @(negedge clk); t++; end
    chk("d5_done_seen", done5, 1);
    @(negedge clk);
    chk("d5_gap_idle", busy5, 0);
    chk("d5_ncs", ncs_v[1], 1);
    #1;
    chk("d5_bits", l_frame[1], 16'h8A3C);
    chk("d5_ncs_low", l_low[1], 165);
    chk("d5_rises", l_nr[1], 16);
    chk("d5_hi_min", l_hmin[1], 5);
    chk("d5_hi_max", l_hmax[1], 5);
    chk("d5_lo_min", l_lmin[1], 5);
    chk("d5_lo_max", l_lmax[1], 5);
    chk("d5_done", done_cnt[1] - d0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_write_controller.md
SPI_WRITE_CONTROLLER -- requirements
Module: spi_write_controller

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period; legal range 4..255.
REQ-002 SHALL provide parameter GAP_CYCLES, default 4, meaning the minimum clk cycles nCS stays high between frames; legal range 1..255.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4, meaning command queue entries; legal values are powers of two from 2 to 16.
REQ-004 SHALL provide port clk  input  1  system clock; all logic is on its rising edge.
REQ-005 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port cmd_valid  input  1  a command is offered.
REQ-007 SHALL provide port cmd_ready  output  1  the queue can accept a command.
REQ-008 SHALL provide port cmd_write  input  1  frame bit 15 (1 = register write, 0 = read/ignored).
REQ-009 SHALL provide port cmd_addr  input  7  target register address, frame bits 14:8.
REQ-010 SHALL provide port cmd_data  input  8  register data, frame bits 7:0.
REQ-011 SHALL provide port SCLK  output  1  serial clock, mode 0, idle low.
REQ-012 SHALL provide port COPI  output  1  serial data, MSB first.
REQ-013 SHALL provide port nCS  output  1  active-low frame select.
REQ-014 SHALL provide port busy  output  1  high while the queue is non-empty, a frame is active or the gap is running.
REQ-015 SHALL provide port done  output  1  one-cycle pulse per completed frame.
REQ-016 SHALL provide port level  output  clog2(FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-017 SHALL accept a command on any rising edge where cmd_valid and cmd_ready are both high, storing {cmd_write, cmd_addr, cmd_data} as one 16-bit frame in the FIFO.
REQ-018 SHALL drive cmd_ready = (level < FIFO_DEPTH), with no push-through when full, even if a pop occurs in the same cycle.
REQ-019 SHALL apply a simultaneous push and pop in one cycle, leaving level unchanged.
REQ-020 SHALL implement the states IDLE, SETUP, SCLK_HI, SCLK_LO and GAP.
- IDLE with FIFO non-empty: pop the head entry and go to SETUP; on that edge nCS goes to 0 and COPI to frame bit 15.
REQ-021 SHALL hold SETUP for CLK_DIV cycles with SCLK=0, then enter SCLK_HI.
REQ-022 SHALL hold SCLK_HI for CLK_DIV cycles with SCLK=1 and COPI stable, then enter SCLK_LO.
REQ-023 SHALL hold SCLK_LO for CLK_DIV cycles with SCLK=0.
- COPI updates to the next lower bit on the edge that enters SCLK_LO, except after bit 0.
REQ-024 SHALL use a 4-bit bit counter that decrements 15 to 0 with no wrap.
- After the SCLK_LO that follows bit 0, the controller SHALL enter GAP with nCS=1, COPI=0 and done=1 for exactly that one cycle.
REQ-025 SHALL hold nCS low for exactly CLK_DIV*33 cycles per frame (132 at default) and produce exactly 16 SCLK rising edges.
REQ-026 SHALL hold GAP for GAP_CYCLES cycles, then return to IDLE; back-to-back frames therefore show nCS high for at least GAP_CYCLES+1 cycles.
REQ-027 SHALL give a latency of one edge from command acceptance to nCS low when the controller is IDLE and the FIFO is empty (accept on edge k, nCS low after edge k+1).
REQ-028 SHALL ignore cmd_valid while cmd_ready is low, and SHALL NOT alter the frame in flight when the FIFO is written.
REQ-029 SHALL serve FIFO entries strictly in arrival order, with read and write pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-030 SHALL, on rst=1 at a rising edge, set SCLK=0, COPI=0, nCS=1, done=0, busy=0 and level=0, flush the FIFO and go to IDLE, with rst taking priority over all other events.
REQ-031 SHALL abort a frame when reset is asserted mid-frame: nCS rises on that edge, no done pulse is produced, and the aborted and queued commands are discarded.
REQ-032 SHALL keep cmd_ready low while rst is high.

Verification
REQ-033 SHALL verify a single write: push {1, 7'h04, 8'hA5} while idle -> COPI samples on the 16 SCLK rising edges read 16'h84A5, nCS is low for 132 cycles, and done pulses once.
REQ-034 SHALL verify back-to-back frames: push 16'h8011 and 16'h8122 on consecutive cycles -> two frames in order, nCS high for at least 5 cycles between them, and two done pulses.
REQ-035 SHALL verify the full queue: push 6 commands with cmd_valid held high while the controller is idle -> the first is popped and 4 are queued, cmd_ready drops with level=4, the 6th is stalled until a pop, and no command is lost or duplicated.
REQ-036 SHALL verify reset mid-frame: assert rst after the 8th SCLK rise with 2 commands queued -> nCS=1 on the next edge, no done, level=0, and the next push produces a clean frame.
REQ-037 SHALL verify a read frame: push {0, 7'h02, 8'h00} -> frame 16'h0200 is shifted with identical timing and done pulses once.
REQ-038 SHALL verify CLK_DIV=5 and GAP_CYCLES=1: one frame -> SCLK high and low phases are 5 cycles each, nCS is low for 165 cycles, and GAP returns to IDLE after 1 cycle.
